// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - Shared UART receive/transmit types, line levels and baud timing helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uartState_t;

  localparam int   UART_DATA_BITS = 8;
  localparam logic IDLE_LEVEL     = 1'b1;
  localparam logic START_LEVEL    = 1'b0;
  localparam logic STOP_LEVEL     = 1'b1;

  function automatic int symbolEdgeTime(input int clockFreq, input int baudRate);
    return clockFreq / baudRate;
  endfunction

  function automatic int counterWidth(input int edgeTime);
    return $clog2(edgeTime + 1);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - Bit-period counter giving mid-bit and bit-edge ticks.
module uart_bit_timer #(
  parameter int SymbolEdgeTime = 868
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic mid_tick,
  output logic edge_tick
);
  import uart_pkg::*;

  localparam int CountWidth = counterWidth(SymbolEdgeTime);
  localparam logic [CountWidth-1:0] EdgeCount   = CountWidth'(SymbolEdgeTime);
  localparam logic [CountWidth-1:0] SampleCount = CountWidth'(SymbolEdgeTime / 2);

  logic [CountWidth-1:0] count;

  assign mid_tick  = (count == SampleCount);
  assign edge_tick = (count == EdgeCount);

  // The clearing edge counts as cycle one, so edge_tick recurs every SymbolEdgeTime cycles
  // and the count never runs past its terminal value.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear || edge_tick) begin
      count <= CountWidth'(1);
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART receive half: 8N1 deserializer with a valid/ready byte port.
// Defining UART_RX_PARITY_EN adds an even parity bit and the ParityError port.
module uart_receiver #(
  parameter int ClockFreq = 100_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       SIn,
  output logic [7:0] DataOut,
  output logic       DataOutValid,
  input  logic       DataOutReady,
  output logic       FramingError,
  output logic       Overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       ParityError
`endif
);
  import uart_pkg::*;

  localparam int SymbolEdgeTime = symbolEdgeTime(ClockFreq, BaudRate);

  uartState_t state, nextState;
  logic syncMeta, lineSync;
  logic [UART_DATA_BITS-1:0] shiftReg;
  logic [2:0] bitIdx;
  logic timerClear, midTick, edgeTick;
  logic dataSample, stopSample, frameGood, holdingByte;
`ifdef UART_RX_PARITY_EN
  logic paritySample, parityBad;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      syncMeta <= IDLE_LEVEL;
      lineSync <= IDLE_LEVEL;
    end else begin
      syncMeta <= SIn;
      lineSync <= syncMeta;
    end
  end

  uart_bit_timer #(
    .SymbolEdgeTime(SymbolEdgeTime)
  ) bitTimer (
    .clock    (Clock),
    .reset    (Reset),
    .clear    (timerClear),
    .mid_tick (midTick),
    .edge_tick(edgeTick)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState  = state;
    timerClear = 1'b0;
    dataSample = 1'b0;
    stopSample = 1'b0;
`ifdef UART_RX_PARITY_EN
    paritySample = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (lineSync == START_LEVEL) begin
          timerClear = 1'b1;
          nextState  = START;
        end
      end
      START: begin
        if (midTick) begin
          if (lineSync == START_LEVEL) begin
            timerClear = 1'b1;
            nextState  = DATA;
          end else begin
            nextState = IDLE;
          end
        end
      end
      DATA: begin
        if (edgeTick) begin
          dataSample = 1'b1;
          if (bitIdx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            nextState = PARITY;
`else
            nextState = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (edgeTick) begin
          paritySample = 1'b1;
          nextState    = STOP;
        end
      end
`endif
      STOP: begin
        // Leaving mid-stop-bit gives half a bit of slack to catch a back-to-back start edge.
        if (edgeTick) begin
          stopSample = 1'b1;
          nextState  = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      shiftReg <= '0;
      bitIdx   <= '0;
`ifdef UART_RX_PARITY_EN
      parityBad <= 1'b0;
`endif
    end else begin
      if (state != DATA)   bitIdx <= '0;
      else if (dataSample) bitIdx <= bitIdx + 1'b1;
      if (dataSample) shiftReg <= {lineSync, shiftReg[UART_DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
      if (paritySample) parityBad <= (^shiftReg) ^ lineSync;
`endif
    end
  end

`ifdef UART_RX_PARITY_EN
  assign frameGood = stopSample && (lineSync == STOP_LEVEL) && !parityBad;
`else
  assign frameGood = stopSample && (lineSync == STOP_LEVEL);
`endif

  // A byte accepted on this edge frees the holding slot for a byte landing on the same edge.
  assign holdingByte = DataOutValid && !DataOutReady;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      DataOut      <= '0;
      DataOutValid <= 1'b0;
      FramingError <= 1'b0;
      Overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      ParityError  <= 1'b0;
`endif
    end else begin
      FramingError <= stopSample && (lineSync != STOP_LEVEL);
      Overrun      <= frameGood && holdingByte;
`ifdef UART_RX_PARITY_EN
      ParityError  <= stopSample && (lineSync == STOP_LEVEL) && parityBad;
`endif
      if (DataOutValid && DataOutReady) DataOutValid <= 1'b0;
      if (frameGood && !holdingByte) begin
        DataOut      <= shiftReg;
        DataOutValid <= 1'b1;
      end
    end
  end

endmodule
